// File: rtl/bdd_mem_pkg.sv
// Shared defaults and request type for the BDD node-store memory path.
package bdd_mem_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 6;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned RSP_DEPTH_DEF  = 4;
  localparam int unsigned CNT_WIDTH_DEF  = 16;

  typedef struct packed {
    logic                      write;
    logic [ADDR_WIDTH_DEF-1:0] addr;
    logic [DATA_WIDTH_DEF-1:0] data;
  } mem_req_t;

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous FIFO with arbitrary depth, occupancy count and synchronous active-high reset.
module rsp_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_push,
  input  logic [WIDTH-1:0]             i_data,
  input  logic                         i_pop,
  output logic [WIDTH-1:0]             o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Wrap explicitly so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

endmodule

// File: rtl/sram.sv
// Single-port synchronous SRAM: write commits at the edge, read data registered one cycle late.
module sram #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  i_clk,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic                  i_write,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic [DATA_WIDTH-1:0] o_data
);

  logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_write) begin
      r_mem[i_addr] <= i_data;
    end
    o_data <= r_mem[i_addr];
  end

endmodule

// File: rtl/sram_req_ctrl.sv
// Valid/ready request front-end for the node-store SRAM with credit-protected read response FIFO.
module sram_req_ctrl
  import bdd_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned RSP_DEPTH  = RSP_DEPTH_DEF,
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_write,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_write,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [CNT_WIDTH-1:0]  o_rd_count,
  output logic [CNT_WIDTH-1:0]  o_wr_count
);

  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);

  logic                 r_rd_pending;
  logic [CNT_WIDTH-1:0] r_rd_count;
  logic [CNT_WIDTH-1:0] r_wr_count;
  logic [CW-1:0]        w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic [CW:0]          w_credit_used;
  logic                 w_accept;
  logic                 w_pop;

  // Credits cover both buffered data and the read still in the SRAM pipeline.
  assign w_credit_used = {1'b0, w_fifo_count} + (CW + 1)'(r_rd_pending);
  assign o_req_ready   = ~i_rst & ~w_fifo_full & (w_credit_used < (CW + 1)'(RSP_DEPTH));
  assign w_accept      = i_req_valid & o_req_ready;

  assign o_mem_addr  = i_req_addr;
  assign o_mem_data  = i_req_data;
  assign o_mem_write = w_accept & i_req_write;

  assign o_rsp_valid = ~i_rst & ~w_fifo_empty;
  assign w_pop       = o_rsp_valid & i_rsp_ready;
  assign o_rd_count  = r_rd_count;
  assign o_wr_count  = r_wr_count;

  rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_rd_pending),
    .i_data  (i_mem_rdata),
    .i_pop   (w_pop),
    .o_data  (o_rsp_data),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_pending <= 1'b0;
      r_rd_count   <= '0;
      r_wr_count   <= '0;
    end else begin
      r_rd_pending <= w_accept & ~i_req_write;
      if (w_accept & ~i_req_write) r_rd_count <= r_rd_count + 1'b1;
      if (w_accept & i_req_write)  r_wr_count <= r_wr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_req_ctrl.sv
// Bench for sram_req_ctrl driving the real sram, with a queue-based response model plus directed checks.
module tb_sram_req_ctrl;
  import bdd_mem_pkg::*;

  localparam int unsigned AW    = 6;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CWID  = 16;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_req_valid;
  logic            o_req_ready;
  logic            i_req_write;
  logic [AW-1:0]   i_req_addr;
  logic [DW-1:0]   i_req_data;
  logic            o_rsp_valid;
  logic            i_rsp_ready;
  logic [DW-1:0]   o_rsp_data;
  logic [AW-1:0]   mem_addr;
  logic            mem_write;
  logic [DW-1:0]   mem_wdata;
  logic [DW-1:0]   mem_rdata;
  logic [CWID-1:0] o_rd_count;
  logic [CWID-1:0] o_wr_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  sram_req_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH),
    .CNT_WIDTH  (CWID)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_write (i_req_write),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_rsp_valid (o_rsp_valid),
    .i_rsp_ready (i_rsp_ready),
    .o_rsp_data  (o_rsp_data),
    .o_mem_addr  (mem_addr),
    .o_mem_write (mem_write),
    .o_mem_data  (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_rd_count  (o_rd_count),
    .o_wr_count  (o_wr_count)
  );

  sram #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) u_sram (
    .i_clk   (i_clk),
    .i_addr  (mem_addr),
    .i_write (mem_write),
    .i_data  (mem_wdata),
    .o_data  (mem_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: every accepted read owes one response, visible two cycles later, popped in order.
  typedef struct {
    logic [DW-1:0] d;
    int            vis;
  } ent_t;

  ent_t            q[$];
  logic [DW-1:0]   m_mem [2**AW];
  logic [CWID-1:0] e_rd = '0;
  logic [CWID-1:0] e_wr = '0;
  int              cyc  = 0;
  bit              live = 0;

  always @(negedge i_clk) begin
    logic e_ready;
    logic e_valid;
    logic acc;
    if (i_rst) live = 1;
    if (live) begin
      e_ready = !i_rst && (q.size() < DEPTH);
      e_valid = !i_rst && (q.size() > 0) && (q[0].vis <= cyc);
      acc     = i_req_valid && e_ready;
      chk("m_req_ready", o_req_ready, e_ready);
      chk("m_rsp_valid", o_rsp_valid, e_valid);
      if (e_valid) chk("m_rsp_data", o_rsp_data, q[0].d);
      chk("m_mem_write", mem_write, acc && i_req_write);
      if (!i_rst) begin
        chk("m_rd_count", o_rd_count, e_rd);
        chk("m_wr_count", o_wr_count, e_wr);
        chk("m_mem_addr", mem_addr, i_req_addr);
        if (dut.r_rd_pending) chk("m_no_overflow", dut.w_fifo_count == DEPTH, 0);
      end
      if (i_rst) begin
        q.delete();
        e_rd = '0;
        e_wr = '0;
      end else begin
        if (e_valid && i_rsp_ready) void'(q.pop_front());
        if (acc) begin
          if (i_req_write) begin
            m_mem[i_req_addr] = i_req_data;
            e_wr++;
          end else begin
            q.push_back('{d: m_mem[i_req_addr], vis: cyc + 2});
            e_rd++;
          end
        end
      end
    end
    cyc++;
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Holds a request until accepted; returns one cycle after acceptance.
  task automatic issue(input mem_req_t r);
    bit got = 0;
    int n   = 0;
    i_req_valid = 1'b1;
    i_req_write = r.write;
    i_req_addr  = r.addr;
    i_req_data  = r.data;
    while (!got && n < 50) begin
      @(negedge i_clk);
      got = o_req_ready;
      step();
      n++;
    end
    if (!got) chk("issue_timeout", 0, 1);
    i_req_valid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int n_acc;
    int nr;
    int nw;
    int budget;
    i_rst       = 1'b1;
    i_req_valid = 1'b0;
    i_req_write = 1'b0;
    i_req_addr  = '0;
    i_req_data  = '0;
    i_rsp_ready = 1'b1;
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 1'b0;

    @(negedge i_clk);
    chk("rst_ready", o_req_ready, 1);
    chk("rst_valid", o_rsp_valid, 0);
    chk("rst_rd_count", o_rd_count, 0);
    chk("rst_wr_count", o_wr_count, 0);
    step();

    // Write 5 = A5, read 5: response exactly two cycles after acceptance.
    issue('{write: 1'b1, addr: 6'd5, data: 8'hA5});
    issue('{write: 1'b0, addr: 6'd5, data: 8'h00});
    @(negedge i_clk);
    chk("t1_valid_early", o_rsp_valid, 0);
    step();
    @(negedge i_clk);
    chk("t1_valid", o_rsp_valid, 1);
    chk("t1_data", o_rsp_data, 8'hA5);
    chk("t1_wr_count", o_wr_count, 1);
    chk("t1_rd_count", o_rd_count, 1);
    step();

    // Same-address read immediately after write.
    i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = 6'd3; i_req_data = 8'h3C;
    @(negedge i_clk);
    chk("t2_ready_w", o_req_ready, 1);
    step();
    i_req_write = 1'b0;
    @(negedge i_clk);
    chk("t2_ready_r", o_req_ready, 1);
    step();
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("t2_valid_early", o_rsp_valid, 0);
    step();
    @(negedge i_clk);
    chk("t2_valid", o_rsp_valid, 1);
    chk("t2_data", o_rsp_data, 8'h3C);
    step();

    for (int a = 0; a < 64; a++) begin
      i_req_valid = 1'b1; i_req_write = 1'b1; i_req_addr = AW'(a); i_req_data = DW'(a);
      @(negedge i_clk);
      step();
    end
    i_req_valid = 1'b0;

    // Ten streaming reads with the consumer always ready.
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = AW'(k);
      end else begin
        i_req_valid = 1'b0;
      end
      @(negedge i_clk);
      if (k < 10) chk("t3_ready", o_req_ready, 1);
      if (k >= 2) begin
        chk("t3_valid", o_rsp_valid, 1);
        chk("t3_data", o_rsp_data, k - 2);
      end
      step();
    end

    // Stalled consumer: credit limit stops acceptance at DEPTH reads.
    i_rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = AW'(20 + acc);
      @(negedge i_clk);
      if (o_req_ready) acc++;
      step();
    end
    chk("t4_accepted", acc, 4);
    i_req_valid = 1'b0;
    @(negedge i_clk);
    chk("t4_ready_low", o_req_ready, 0);
    chk("t4_data_held", o_rsp_data, 20);
    step();
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge i_clk);
      chk("t4_valid", o_rsp_valid, 1);
      chk("t4_data", o_rsp_data, 20 + k);
      step();
    end
    @(negedge i_clk);
    chk("t4_ready_back", o_req_ready, 1);
    chk("t4_drained", o_rsp_valid, 0);
    step();

    // Mid-operation reset with two buffered responses and one in flight.
    i_rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_req_valid = 1'b1; i_req_write = 1'b0; i_req_addr = AW'(30 + k);
      @(negedge i_clk);
      chk("t5_ready", o_req_ready, 1);
      step();
    end
    i_req_valid = 1'b0;
    i_rst = 1'b1;
    @(negedge i_clk);
    chk("t5_rst_ready", o_req_ready, 0);
    chk("t5_rst_valid", o_rsp_valid, 0);
    step();
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("t5_post_valid", o_rsp_valid, 0);
    chk("t5_post_ready", o_req_ready, 1);
    chk("t5_post_rd", o_rd_count, 0);
    chk("t5_post_wr", o_wr_count, 0);
    i_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      @(negedge i_clk);
      chk("t5_no_stale", o_rsp_valid, 0);
    end
    step();
    issue('{write: 1'b0, addr: 6'd30, data: 8'h00});
    @(negedge i_clk);
    step();
    @(negedge i_clk);
    chk("t5_mem_kept_valid", o_rsp_valid, 1);
    chk("t5_mem_kept_data", o_rsp_data, 30);
    step();

    // Random traffic from a fresh reset.
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    n_acc = 0; nr = 0; nw = 0; budget = 0;
    while (n_acc < 2000 && budget < 20000) begin
      i_req_valid = ($urandom_range(0, 3) != 0);
      i_req_write = 1'($urandom_range(0, 1));
      i_req_addr  = AW'($urandom_range(0, 63));
      i_req_data  = DW'($urandom_range(0, 255));
      i_rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge i_clk);
      if (i_req_valid && o_req_ready) begin
        n_acc++;
        if (i_req_write) nw++;
        else nr++;
      end
      step();
      budget++;
    end
    if (n_acc < 2000) chk("rand_budget", n_acc, 2000);
    i_req_valid = 1'b0;
    i_rsp_ready = 1'b1;
    repeat (8) step();
    @(negedge i_clk);
    chk("rand_rd_total", o_rd_count, CWID'(nr));
    chk("rand_wr_total", o_wr_count, CWID'(nw));
    chk("rand_drained", o_rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
